// File: rtl/serial_sum_deserializer_if.sv
// rtl/serial_sum_deserializer_if.sv - serial sum stream and parallel result handshake bundle
//
// Purpose: groups the serial input side (start, bit_in, bit_valid, carry_in)
// and the parallel result side (sum_out, carry_out, out_valid, out_ready,
// busy, overrun) of the bit-serial sum deserializer.
//   master : serial adder / downstream consumer side (drives stream, ready)
//   slave  : deserializer side (drives result, status)
interface serial_sum_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             carry_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output start, bit_in, bit_valid, carry_in, out_ready,
    input  sum_out, carry_out, out_valid, busy, overrun
  );

  modport slave (
    input  start, bit_in, bit_valid, carry_in, out_ready,
    output sum_out, carry_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/serial_sum_deserializer.sv
// rtl/serial_sum_deserializer.sv - LSB-first serial sum plus final carry to parallel result
//
// Purpose: receive end of the bit-serial adder. Shifts in WIDTH sum bits
// (LSB first, only on bit_valid cycles), captures the final carry with the
// last bit, and holds the result on a valid/ready handshake.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      slave modport: start, bit_in, bit_valid, carry_in, out_ready in;
//            sum_out, carry_out, out_valid, busy, overrun out
module serial_sum_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  serial_sum_deserializer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;
  logic             r_overrun;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_carry_nxt;
  logic             w_valid_nxt;
  logic             w_overrun_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_handshake;

  assign w_shifted   = {bus.bit_in, r_shreg[WIDTH-1:1]};
  assign w_handshake = r_valid & bus.out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_sum     <= w_sum_nxt;
      r_carry   <= w_carry_nxt;
      r_valid   <= w_valid_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shreg_nxt   = r_shreg;
    w_sum_nxt     = r_sum;
    w_carry_nxt   = r_carry;
    w_valid_nxt   = r_valid;
    w_overrun_nxt = r_overrun;

    unique case (r_state)
      IDLE: begin
        // Stray bits while idle are not an error; only start matters.
        if (bus.start) begin
          w_state_nxt = COLLECT;
          w_cnt_nxt   = '0;
          w_shreg_nxt = '0;
        end
      end

      COLLECT: begin
        // A restart discards the partial frame, including a bit in the same cycle.
        if (bus.start) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = '0;
        end else if (bus.bit_valid) begin
          w_shreg_nxt = w_shifted;
          if (r_cnt == LAST_IDX) begin
            w_sum_nxt   = w_shifted;
            w_carry_nxt = bus.carry_in;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      HOLD: begin
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          // Back-to-back frames: a start with the accept skips IDLE entirely.
          if (bus.start) begin
            w_state_nxt = COLLECT;
            w_cnt_nxt   = '0;
            w_shreg_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (bus.bit_valid || bus.start) begin
          // Input arriving while the result is still unclaimed is lost.
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.sum_out   = r_sum;
  assign bus.carry_out = r_carry;
  assign bus.out_valid = r_valid;
  assign bus.busy      = (r_state != IDLE);
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// tb/tb_serial_sum_deserializer.sv - self-checking bench for serial_sum_deserializer
module tb_serial_sum_deserializer;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic exp_ov;

  serial_sum_deserializer_if #(.WIDTH(W)) bus ();

  serial_sum_deserializer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.carry_in  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Send bits [first, first+n) of value LSB first; gap_mode 0 = none,
  // 1 = one idle cycle between bits, 2 = random idle cycles with junk bit_in.
  // No result may be presented before the final bit of the frame.
  task automatic send_bits(input logic [W-1:0] value, input logic carry,
                           input int first, input int n, input int gap_mode);
    for (int i = first; i < first + n; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = value[i];
      bus.carry_in  = (i == W - 1) ? carry : 1'b0;
      tick();
      bus.bit_valid = 1'b0;
      bus.carry_in  = 1'b0;
      if (i != W - 1) begin
        check("no_early_valid", {31'd0, bus.out_valid}, 32'd0);
        if (gap_mode == 1) tick();
        if (gap_mode == 2) begin
          int gaps = $urandom_range(0, 2);
          for (int g = 0; g < gaps; g++) begin
            bus.bit_in = 1'($urandom);
            tick();
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] sum, input logic carry);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_sum"}, {24'd0, bus.sum_out}, {24'd0, sum});
    check({tag, "_carry"}, {31'd0, bus.carry_out}, {31'd0, carry});
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("accept_valid", {31'd0, bus.out_valid}, 32'd0);
    check("accept_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    exp_ov = 1'b0;
    idle_inputs();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_sum", {24'd0, bus.sum_out}, 32'd0);
    check("rst_ov", {31'd0, bus.overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Consecutive bits, ready held high.
    bus.out_ready = 1'b1;
    pulse_start();
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    send_bits(8'hA5, 1'b1, 0, W, 0);
    check_result("t1", 8'hA5, 1'b1);
    tick();
    check("t1_done_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t1_done_busy", {31'd0, bus.busy}, 32'd0);
    bus.out_ready = 1'b0;

    // Idle cycles between valid bits are not counted.
    pulse_start();
    send_bits(8'h3C, 1'b0, 0, W, 1);
    check_result("t2", 8'h3C, 1'b0);
    accept();

    // Late consumer: a bit during HOLD sets the sticky overrun.
    pulse_start();
    send_bits(8'h5A, 1'b0, 0, W, 0);
    for (int c = 0; c < 5; c++) begin
      bus.bit_valid = (c == 2);
      bus.bit_in    = 1'b1;
      tick();
    end
    idle_inputs();
    check_result("t3", 8'h5A, 1'b0);
    check("t3_ov", {31'd0, bus.overrun}, 32'd1);
    accept();
    check("t3_ov_sticky", {31'd0, bus.overrun}, 32'd1);

    // Abort after three bits; only the restarted frame completes.
    pulse_start();
    send_bits(8'hFF, 1'b0, 0, 3, 0);
    pulse_start();
    send_bits(8'h0F, 1'b1, 0, W, 0);
    check_result("t4", 8'h0F, 1'b1);
    accept();

    // Asynchronous reset mid-frame, then start-less bits are ignored.
    pulse_start();
    send_bits(8'h96, 1'b0, 0, 4, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_ov", {31'd0, bus.overrun}, 32'd0);
    check("t5_sum", {24'd0, bus.sum_out}, 32'd0);
    check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_bits(8'hFF, 1'b1, 0, W, 0);
    check("t5_nostart_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_nostart_busy", {31'd0, bus.busy}, 32'd0);

    // Accept and restart in the same cycle: no idle gap.
    pulse_start();
    send_bits(8'h81, 1'b0, 0, W, 0);
    check_result("t6a", 8'h81, 1'b0);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    idle_inputs();
    bus.out_ready = 1'b0;
    check("t6_busy", {31'd0, bus.busy}, 32'd1);
    check("t6_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    send_bits(8'hFF, 1'b1, 0, W, 0);
    check_result("t6b", 8'hFF, 1'b1);
    check("t6_ov", {31'd0, bus.overrun}, 32'd0);
    accept();

    // Random frames: random gaps, random consumer delay with stray traffic.
    exp_ov = 1'b0;
    for (int f = 0; f < 24; f++) begin
      logic [W-1:0] val;
      logic         cy;
      int           dly;
      val = W'($urandom);
      cy  = 1'($urandom);
      pulse_start();
      send_bits(val, cy, 0, W, 2);
      check_result("rnd", val, cy);
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        bus.bit_valid = ($urandom_range(0, 3) == 0);
        bus.start     = ($urandom_range(0, 7) == 0);
        bus.bit_in    = 1'($urandom);
        if (bus.bit_valid || bus.start) exp_ov = 1'b1;
        tick();
      end
      idle_inputs();
      check("rnd_hold_sum", {24'd0, bus.sum_out}, {24'd0, val});
      check("rnd_ov", {31'd0, bus.overrun}, {31'd0, exp_ov});
      accept();
      check("rnd_keep_sum", {24'd0, bus.sum_out}, {24'd0, val});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
